// File: rtl/period_meter_pkg.sv
// Shared types and helpers for the period meter: FSM state encoding and
// the default timeout count for a given counter width.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    // All-ones value of a WIDTH-bit counter, used as the default timeout count.
    function automatic logic [63:0] cnt_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Multi-stage synchronizer for an asynchronous level, followed by a
// single-cycle rising-edge detector on the synchronized level.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   level_d_r;

    // Synchronizer chain plus one delay stage for edge detection.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_r    <= '0;
            level_d_r <= 1'b0;
        end else begin
            sync_r    <= {sync_r[SYNC_STAGES-2:0], d_i};
            level_d_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_r[SYNC_STAGES-1];
    assign rise_o  = sync_r[SYNC_STAGES-1] & ~level_d_r;

endmodule

// File: rtl/period_meter.sv
// Measures the spacing, in clk_i cycles, between consecutive rising edges
// of a slow (possibly asynchronous) signal, with a timeout for lost edges.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] MAX_COUNT   = WIDTH'(cnt_max(WIDTH))
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             enable_i,
    input  logic             sig_i,
    output logic [WIDTH-1:0] period_o,
    output logic             valid_o,
    output logic             timeout_o,
    output logic             busy_o
);

    localparam logic [1:0] ST_IDLE    = 2'(IDLE);
    localparam logic [1:0] ST_ARM     = 2'(ARM);
    localparam logic [1:0] ST_MEASURE = 2'(MEASURE);

    logic             level_unused_s;
    logic             rise_s;

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_s;
    logic [WIDTH-1:0] period_r;
    logic [WIDTH-1:0] period_s;
    logic             valid_r;
    logic             valid_s;
    logic             timeout_r;
    logic             timeout_s;
    logic             busy_r;
    logic             busy_s;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (sig_i),
        .level_o(level_unused_s),
        .rise_o (rise_s)
    );

    // Next-state, counter and result logic for the measurement FSM.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        period_s  = period_r;
        valid_s   = 1'b0;
        timeout_s = 1'b0;
        if (!enable_i) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_ARM;
                end
                ST_ARM: begin
                    // The first edge only starts the count; no result yet.
                    if (rise_s) begin
                        state_s = ST_MEASURE;
                        cnt_s   = WIDTH'(1'b1);
                    end else begin
                        cnt_s   = cnt_r;
                    end
                end
                ST_MEASURE: begin
                    // An edge on the timeout cycle still counts as a result.
                    if (rise_s) begin
                        period_s = cnt_r;
                        valid_s  = 1'b1;
                        cnt_s    = WIDTH'(1'b1);
                    end else if (cnt_r == MAX_COUNT) begin
                        timeout_s = 1'b1;
                        cnt_s     = '0;
                        state_s   = ST_ARM;
                    end else begin
                        cnt_s     = cnt_r + WIDTH'(1'b1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end
            endcase
        end
        busy_s = (state_s == ST_MEASURE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            period_r  <= '0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            period_r  <= period_s;
            valid_r   <= valid_s;
            timeout_r <= timeout_s;
            busy_r    <= busy_s;
        end
    end

    assign period_o  = period_r;
    assign valid_o   = valid_r;
    assign timeout_o = timeout_r;
    assign busy_o    = busy_r;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter (WIDTH=8, MAX_COUNT=255): steady and
// divided inputs, timeout and its boundary, enable drops and async reset.
module tb_period_meter;

    logic       clk_i;
    logic       rstn_i;
    logic       enable_i;
    logic       sig_i;
    logic [7:0] period_o;
    logic       valid_o;
    logic       timeout_o;
    logic       busy_o;

    int         n_checks;
    int         n_pass;
    int         n_valid;
    int         n_timeout;
    int         v0;
    int         t0;
    int         bc;
    logic       seen;
    logic [7:0] exp_period;
    logic [7:0] last_period;

    period_meter #(
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .MAX_COUNT  (8'd255)
    ) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .enable_i (enable_i),
        .sig_i    (sig_i),
        .period_o (period_o),
        .valid_o  (valid_o),
        .timeout_o(timeout_o),
        .busy_o   (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Inputs change on the falling edge, away from the DUT's sampling edge.
    task automatic tick(input logic s, input logic en);
        @(negedge clk_i);
        sig_i    = s;
        enable_i = en;
    endtask

    task automatic drive_period(input int hi, input int lo);
        repeat (hi) tick(1'b1, 1'b1);
        repeat (lo) tick(1'b0, 1'b1);
    endtask

    // Period of 10 (5 high) with enable low for exactly one cycle at 'drop'.
    task automatic drop_period(input int drop);
        for (int k = 0; k < 10; k++) tick((k < 5), (k != drop));
    endtask

    task automatic rearm();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
    endtask

    // Result monitor: every valid carries the expected period; period_o only moves with valid.
    initial begin
        last_period = 8'd0;
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                last_period = period_o;
            end else begin
                if (valid_o) begin
                    check("period", int'(period_o), int'(exp_period));
                    check("busy_on_valid", int'(busy_o), 1);
                    n_valid++;
                end
                if (timeout_o) n_timeout++;
                if (valid_o || timeout_o) check("valid_timeout_excl", int'(valid_o & timeout_o), 0);
                if (period_o != last_period) begin
                    check("period_hold", int'(valid_o), 1);
                    last_period = period_o;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        n_valid    = 0;
        n_timeout  = 0;
        rstn_i     = 1'b0;
        enable_i   = 1'b0;
        sig_i      = 1'b0;
        exp_period = 8'd10;
        repeat (3) @(negedge clk_i);
        check("rst_period", int'(period_o), 0);
        check("rst_valid", int'(valid_o), 0);
        check("rst_timeout", int'(timeout_o), 0);
        check("rst_busy", int'(busy_o), 0);
        rstn_i   = 1'b1;
        enable_i = 1'b1;

        // Steady period 10: six rises, the first only arms.
        v0 = n_valid; t0 = n_timeout;
        repeat (6) drive_period(5, 5);
        repeat (8) tick(1'b0, 1'b1);
        check("steady_valids", n_valid - v0, 5);
        check("steady_timeouts", n_timeout - t0, 0);
        check("steady_busy", int'(busy_o), 1);
        check("steady_period", int'(period_o), 10);

        // Bit 3 of a free-running counter (8/8), then 3/13 duty, both period 16.
        rearm();
        exp_period = 8'd16;
        v0 = n_valid; t0 = n_timeout;
        repeat (5) drive_period(8, 8);
        repeat (4) drive_period(3, 13);
        repeat (6) tick(1'b0, 1'b1);
        check("div_valids", n_valid - v0, 8);
        check("div_timeouts", n_timeout - t0, 0);
        check("div_period", int'(period_o), 16);

        // One edge, then silence: timeout after 255 busy cycles.
        rearm();
        v0 = n_valid; t0 = n_timeout;
        bc = 0; seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick((i < 4) ? 1'b1 : 1'b0, 1'b1);
            if (busy_o) bc++;
            if (timeout_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("to_seen", int'(seen), 1);
        check("to_latency", bc, 255);
        check("to_busy_low", int'(busy_o), 0);
        check("to_period_kept", int'(period_o), 16);
        exp_period = 8'd40;
        repeat (2) drive_period(4, 36);
        repeat (6) tick(1'b0, 1'b1);
        check("to_valids", n_valid - v0, 1);
        check("to_timeouts", n_timeout - t0, 1);
        check("to_period_40", int'(period_o), 40);

        // Edge spacing exactly MAX_COUNT is a valid result.
        rearm();
        exp_period = 8'd255;
        v0 = n_valid; t0 = n_timeout;
        drive_period(4, 251);
        repeat (4) tick(1'b1, 1'b1);
        repeat (6) tick(1'b0, 1'b1);
        check("max_valids", n_valid - v0, 1);
        check("max_timeouts", n_timeout - t0, 0);
        check("max_period", int'(period_o), 255);

        // One cycle longer times out instead.
        rearm();
        v0 = n_valid; t0 = n_timeout;
        drive_period(4, 252);
        repeat (4) tick(1'b1, 1'b1);
        repeat (6) tick(1'b0, 1'b1);
        check("over_valids", n_valid - v0, 0);
        check("over_timeouts", n_timeout - t0, 1);
        check("over_period", int'(period_o), 255);

        // Enable drops: once on a rise in MEASURE, once mid-period.
        rearm();
        exp_period = 8'd10;
        v0 = n_valid; t0 = n_timeout;
        repeat (3) drive_period(5, 5);
        drop_period(2);
        drive_period(5, 5);
        drop_period(7);
        repeat (2) drive_period(5, 5);
        repeat (6) tick(1'b0, 1'b1);
        check("en_valids", n_valid - v0, 4);
        check("en_timeouts", n_timeout - t0, 0);
        check("en_period", int'(period_o), 10);
        check("en_busy", int'(busy_o), 1);

        // Async reset between clock edges clears outputs immediately.
        @(negedge clk_i);
        #2;
        rstn_i = 1'b0;
        #1;
        check("arst_period", int'(period_o), 0);
        check("arst_valid", int'(valid_o), 0);
        check("arst_timeout", int'(timeout_o), 0);
        check("arst_busy", int'(busy_o), 0);
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        v0 = n_valid; t0 = n_timeout;
        repeat (4) drive_period(5, 5);
        repeat (6) tick(1'b0, 1'b1);
        check("arst_valids", n_valid - v0, 3);
        check("arst_timeouts", n_timeout - t0, 0);
        check("arst_period_after", int'(period_o), 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
